// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Carries the BTB prediction (taken flag + predicted target) from fetch
//   through the D and E pipeline registers, checks it against the real branch
//   outcome in E, raises a mispredict with the correct redirect PC and drives
//   the BTB update port exactly once per resolved instruction.
//
// Optional feature macro: BRU_PERF_CNT_EN
//   When defined, adds saturating BranchCnt / MissCnt performance counters.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   PredictF, PredictTargetF   BTB prediction for the instruction in F
//   StallD, FlushD             D register control
//   StallE, FlushE             E register control
//   PCE, IsBranchE, TakenE,
//   TargetE                    actual outcome of the instruction in E
//   MispredictE, RedirectPC    redirect request and correct next PC
//   UpdValid, UpdPC,
//   UpdTaken, UpdTarget        BTB update interface
//   BranchCnt, MissCnt         performance counters (BRU_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PredictF,
  input  logic [ADDR_W-1:0] PredictTargetF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [ADDR_W-1:0] PCE,
  input  logic              IsBranchE,
  input  logic              TakenE,
  input  logic [ADDR_W-1:0] TargetE,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RedirectPC,
  output logic              UpdValid,
  output logic [ADDR_W-1:0] UpdPC,
  output logic              UpdTaken,
  output logic [ADDR_W-1:0] UpdTarget
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  BranchCnt,
  output logic [CNT_W-1:0]  MissCnt
`endif
);

  logic              pred_d_q, pred_e_q;
  logic [ADDR_W-1:0] ptgt_d_q, ptgt_e_q;
  // Set once the stalled instruction in E has already been resolved.
  logic              done_q;

  logic              misp_d, updv_d, updtk_d;
  logic [ADDR_W-1:0] redir_d;
  logic              active;

  // D register: reset > flush > stall > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_d_q <= 1'b0;
      ptgt_d_q <= '0;
    end else if (FlushD) begin
      pred_d_q <= 1'b0;
      ptgt_d_q <= '0;
    end else if (!StallD) begin
      pred_d_q <= PredictF;
      ptgt_d_q <= PredictTargetF;
    end
  end

  // E register plus the resolved-once flag, same priority order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_e_q <= 1'b0;
      ptgt_e_q <= '0;
      done_q   <= 1'b0;
    end else if (FlushE) begin
      pred_e_q <= 1'b0;
      ptgt_e_q <= '0;
      done_q   <= 1'b0;
    end else if (StallE) begin
      if (updv_d || misp_d) begin
        done_q <= 1'b1;
      end
    end else begin
      pred_e_q <= pred_d_q;
      ptgt_e_q <= ptgt_d_q;
      done_q   <= 1'b0;
    end
  end

  // Reset is folded in combinationally so outputs stay low while rst_n=0
  // even though PCE/IsBranchE are live inputs.
  assign active = rst_n && !done_q;

  always_comb begin
    misp_d  = 1'b0;
    updv_d  = 1'b0;
    updtk_d = 1'b0;
    redir_d = '0;
    if (active) begin
      if (pred_e_q) begin
        if (IsBranchE && TakenE) begin
          updv_d  = 1'b1;
          updtk_d = 1'b1;
          if (ptgt_e_q != TargetE) begin
            misp_d  = 1'b1;
            redir_d = TargetE;
          end
        end else begin
          // false taken or BTB alias hit on a non-branch
          misp_d  = 1'b1;
          updv_d  = 1'b1;
          redir_d = PCE + ADDR_W'(4);
        end
      end else if (IsBranchE) begin
        updv_d = 1'b1;
        if (TakenE) begin
          updtk_d = 1'b1;
          misp_d  = 1'b1;
          redir_d = TargetE;
        end
      end
    end
  end

  assign MispredictE = misp_d;
  assign RedirectPC  = redir_d;
  assign UpdValid    = updv_d;
  assign UpdTaken    = updtk_d;
  assign UpdPC       = updv_d ? PCE     : '0;
  assign UpdTarget   = updv_d ? TargetE : '0;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (active && IsBranchE && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      end
      if (misp_d && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign BranchCnt = br_cnt_q;
  assign MissCnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int unsigned AW = 32;
`ifdef BRU_PERF_CNT_EN
  localparam int unsigned CW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          PredictF = 1'b0;
  logic [AW-1:0] PredictTargetF = '0;
  logic          StallD = 1'b0, FlushD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [AW-1:0] PCE = '0;
  logic          IsBranchE = 1'b0, TakenE = 1'b0;
  logic [AW-1:0] TargetE = '0;
  logic          MispredictE, UpdValid, UpdTaken;
  logic [AW-1:0] RedirectPC, UpdPC, UpdTarget;
`ifdef BRU_PERF_CNT_EN
  logic [CW-1:0] BranchCnt, MissCnt;
  int unsigned   exp_br = 0, exp_miss = 0;
`endif

  branch_resolve_unit #(
    .ADDR_W(AW)
`ifdef BRU_PERF_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PredictF(PredictF), .PredictTargetF(PredictTargetF),
    .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
    .PCE(PCE), .IsBranchE(IsBranchE), .TakenE(TakenE), .TargetE(TargetE),
    .MispredictE(MispredictE), .RedirectPC(RedirectPC),
    .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget)
`ifdef BRU_PERF_CNT_EN
    , .BranchCnt(BranchCnt), .MissCnt(MissCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          misp;
    logic [AW-1:0] redir;
    logic          tk;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
  } exp_t;

  typedef struct {
    logic          pred;
    logic [AW-1:0] ptgt;
    logic [AW-1:0] pce;
    logic          isbr;
    logic          tk;
    logic [AW-1:0] tgt;
    int            stall;
    logic          flush;
    logic          e_out;
    logic          e_misp;
    logic [AW-1:0] e_redir;
    logic          e_tk;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every time the DUT presents an update/redirect, pop and compare.
  always @(negedge clk) begin
    if (rst_n && (MispredictE || UpdValid)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output misp=%b updv=%b redir=%h updpc=%h required=none",
                 MispredictE, UpdValid, RedirectPC, UpdPC);
      end else begin
        mon_e = q.pop_front();
        chk("mispredict", AW'(MispredictE), AW'(mon_e.misp));
        chk("redirect_pc", RedirectPC, mon_e.redir);
        chk("upd_valid", AW'(UpdValid), AW'(1));
        chk("upd_taken", AW'(UpdTaken), AW'(mon_e.tk));
        chk("upd_pc", UpdPC, mon_e.pc);
        chk("upd_target", UpdTarget, mon_e.tgt);
      end
    end
  end

  task automatic push_exp(input logic misp, input logic [AW-1:0] redir, input logic tk,
                          input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic isbr);
    exp_t e;
    e.misp = misp; e.redir = redir; e.tk = tk; e.pc = pc; e.tgt = tgt;
    q.push_back(e);
`ifdef BRU_PERF_CNT_EN
    if (isbr && exp_br < 15) exp_br++;
    if (misp && exp_miss < 15) exp_miss++;
`else
    if (isbr) begin end
`endif
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    PredictF = v.pred; PredictTargetF = v.ptgt; IsBranchE = 1'b0; TakenE = 1'b0;
    edge1();                                   // prediction into D
    PredictF = 1'b0; PredictTargetF = '0;
    edge1();                                   // prediction into E
    PCE = v.pce; IsBranchE = v.isbr; TakenE = v.tk; TargetE = v.tgt;
    StallE = (v.stall > 0); FlushE = v.flush;
    if (v.e_out) push_exp(v.e_misp, v.e_redir, v.e_tk, v.pce, v.tgt, v.isbr);
    @(negedge clk); #1;
    repeat (v.stall) begin                     // inputs held: must not re-resolve
      @(posedge clk); #1;
      @(negedge clk); #1;
    end
    chk("missing_output", AW'(q.size()), AW'(0));
    q.delete();
    StallE = 1'b0; FlushE = 1'b0; IsBranchE = 1'b0; TakenE = 1'b0;
    edge1();
  endtask

  vec_t vecs [10] = '{
    //pred ptgt      pce           br tk tgt       st fl  out misp redir         tk
    '{1'b1, 32'h40, 32'h10,       1'b1,1'b1,32'h40, 0,1'b0, 1'b1,1'b0,32'h0,       1'b1},
    '{1'b1, 32'h40, 32'h10,       1'b1,1'b0,32'h40, 0,1'b0, 1'b1,1'b1,32'h14,      1'b0},
    '{1'b1, 32'h40, 32'h10,       1'b0,1'b0,32'h0,  0,1'b0, 1'b1,1'b1,32'h14,      1'b0},
    '{1'b0, 32'h0,  32'h20,       1'b1,1'b1,32'h80, 0,1'b0, 1'b1,1'b1,32'h80,      1'b1},
    '{1'b1, 32'h40, 32'h30,       1'b1,1'b1,32'h44, 0,1'b0, 1'b1,1'b1,32'h44,      1'b1},
    '{1'b0, 32'h0,  32'h50,       1'b1,1'b0,32'h60, 0,1'b0, 1'b1,1'b0,32'h0,       1'b0},
    '{1'b0, 32'h0,  32'h70,       1'b0,1'b1,32'h90, 0,1'b0, 1'b0,1'b0,32'h0,       1'b0},
    '{1'b1, 32'h40, 32'hFFFFFFFC, 1'b1,1'b0,32'h40, 0,1'b0, 1'b1,1'b1,32'h0,       1'b0},
    '{1'b1, 32'h40, 32'h10,       1'b1,1'b0,32'h40, 3,1'b0, 1'b1,1'b1,32'h14,      1'b0},
    '{1'b1, 32'h40, 32'h10,       1'b1,1'b1,32'h48, 0,1'b1, 1'b1,1'b1,32'h48,      1'b1}
  };

  initial begin
    // Reset with a live prediction and a taken branch on the E inputs
    rst_n = 1'b0; PredictF = 1'b1; PredictTargetF = 32'h40;
    PCE = 32'h10; IsBranchE = 1'b1; TakenE = 1'b1; TargetE = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mispredict", AW'(MispredictE), AW'(0));
    chk("rst_redirect", RedirectPC, AW'(0));
    chk("rst_upd_valid", AW'(UpdValid), AW'(0));
    chk("rst_upd_taken", AW'(UpdTaken), AW'(0));
    chk("rst_upd_pc", UpdPC, AW'(0));
    chk("rst_upd_target", UpdTarget, AW'(0));
`ifdef BRU_PERF_CNT_EN
    chk("rst_branch_cnt", AW'(BranchCnt), AW'(0));
    chk("rst_miss_cnt", AW'(MissCnt), AW'(0));
`endif
    // Release mid-cycle: E is empty so the taken branch looks unpredicted
    rst_n = 1'b1; PredictF = 1'b0; PredictTargetF = '0;
    push_exp(1'b1, 32'h80, 1'b1, 32'h10, 32'h80, 1'b1);
    @(negedge clk); #1;
    chk("post_reset_missing_output", AW'(q.size()), AW'(0));
    q.delete();
    IsBranchE = 1'b0; TakenE = 1'b0;
    edge1();

    foreach (vecs[i]) run(vecs[i]);

`ifdef BRU_PERF_CNT_EN
    chk("branch_cnt", AW'(BranchCnt), AW'(exp_br));
    chk("miss_cnt", AW'(MissCnt), AW'(exp_miss));
    for (int k = 0; k < 16; k++) run(vecs[1]);
    chk("branch_cnt_sat", AW'(BranchCnt), AW'(15));
    chk("miss_cnt_sat", AW'(MissCnt), AW'(15));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
